// File: rtl/quad_gen.sv
// Quadrature A/B generator: turns a (direction, step count) command into a
// paced Gray-code sequence, each phase held STEP_CYCLES clocks.
module quad_gen #(
    parameter int STEP_CYCLES = 16,
    parameter int COUNT_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic                   cmd_dir,
    input  logic [COUNT_WIDTH-1:0] cmd_steps,
    output logic                   enc_a,
    output logic                   enc_b,
    output logic                   busy,
    output logic                   done
);
    localparam int TW = $clog2(STEP_CYCLES + 1);
    localparam logic [TW-1:0] TIMER_TERM = TW'(STEP_CYCLES - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t                 state_q, state_d;
    logic                   dir_q, dir_d;
    logic [1:0]             phase_q, phase_d;
    logic [COUNT_WIDTH-1:0] remaining_q, remaining_d;
    logic [TW-1:0]          timer_q, timer_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   zero_pend_q, zero_pend_d;
    logic                   enc_a_q, enc_a_d;
    logic                   enc_b_q, enc_b_d;
    logic                   accept;

    assign accept = cmd_valid && (state_q == IDLE);

    always_comb begin
        state_d     = state_q;
        dir_d       = dir_q;
        phase_d     = phase_q;
        remaining_d = remaining_q;
        timer_d     = timer_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        zero_pend_d = 1'b0;
        case (state_q)
            IDLE: begin
                // A zero-step command reports completion one cycle after acceptance.
                done_d = zero_pend_q;
                if (accept) begin
                    dir_d = cmd_dir;
                    if (cmd_steps == '0) begin
                        zero_pend_d = 1'b1;
                    end else begin
                        remaining_d = cmd_steps;
                        timer_d     = '0;
                        busy_d      = 1'b1;
                        state_d     = RUN;
                    end
                end
            end
            RUN: begin
                if (timer_q == TIMER_TERM) begin
                    timer_d = '0;
                    if (remaining_q != '0) begin
                        phase_d     = dir_q ? phase_q + 2'd1 : phase_q - 2'd1;
                        remaining_d = remaining_q - COUNT_WIDTH'(1);
                    end else begin
                        // Final hold elapsed: finish without moving the phase.
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        // Gray mapping p=0..3 -> {a,b} = 00,10,11,01.
        enc_a_d = phase_d[1] ^ phase_d[0];
        enc_b_d = phase_d[1];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            dir_q       <= 1'b0;
            phase_q     <= 2'd0;
            remaining_q <= '0;
            timer_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            zero_pend_q <= 1'b0;
            enc_a_q     <= 1'b0;
            enc_b_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            dir_q       <= dir_d;
            phase_q     <= phase_d;
            remaining_q <= remaining_d;
            timer_q     <= timer_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            zero_pend_q <= zero_pend_d;
            enc_a_q     <= enc_a_d;
            enc_b_q     <= enc_b_d;
        end
    end

    assign cmd_ready = (state_q == IDLE);
    assign enc_a     = enc_a_q;
    assign enc_b     = enc_b_q;
    assign busy      = busy_q;
    assign done      = done_q;
endmodule

// File: tb/tb_quad_gen.sv
// Bench for quad_gen: per-cycle expected traces from the timing formulas are
// queued at command issue and compared against two DUTs (STEP_CYCLES 4 and 2).
module tb_quad_gen;
    typedef struct packed {
        logic a;
        logic b;
        logic busy;
        logic done;
        logic ready;
    } obs_t;

    logic       clk;
    logic       reset;
    logic       v     [2];
    logic       d     [2];
    logic [7:0] s     [2];
    logic       rdy   [2];
    logic       a     [2];
    logic       b     [2];
    logic       bz    [2];
    logic       dn    [2];

    obs_t       exp_q[$];
    int         total;
    int         bad;
    logic [1:0] ph0, ph1;
    logic [1:0] prev_ab;
    int         up_cnt, dn_cnt;

    quad_gen #(.STEP_CYCLES(4), .COUNT_WIDTH(8)) dut4 (
        .clk(clk), .reset(reset), .cmd_valid(v[0]), .cmd_ready(rdy[0]),
        .cmd_dir(d[0]), .cmd_steps(s[0]), .enc_a(a[0]), .enc_b(b[0]),
        .busy(bz[0]), .done(dn[0])
    );

    quad_gen #(.STEP_CYCLES(2), .COUNT_WIDTH(8)) dut2 (
        .clk(clk), .reset(reset), .cmd_valid(v[1]), .cmd_ready(rdy[1]),
        .cmd_dir(d[1]), .cmd_steps(s[1]), .enc_a(a[1]), .enc_b(b[1]),
        .busy(bz[1]), .done(dn[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [1:0] ab_of(input logic [1:0] p);
        case (p)
            2'd0:    return 2'b00;
            2'd1:    return 2'b10;
            2'd2:    return 2'b11;
            default: return 2'b01;
        endcase
    endfunction

    function automatic logic [1:0] ph_of(input logic [1:0] ab);
        case (ab)
            2'b00:   return 2'd0;
            2'b10:   return 2'd1;
            2'b11:   return 2'd2;
            default: return 2'd3;
        endcase
    endfunction

    function automatic obs_t get_obs(input int sel);
        obs_t o;
        o.a     = a[sel];
        o.b     = b[sel];
        o.busy  = bz[sel];
        o.done  = dn[sel];
        o.ready = rdy[sel];
        return o;
    endfunction

    // Expected observation after edge T0+j, j = 0 .. end of the done cycle.
    task automatic push_trace(input logic [1:0] p0, input logic dir, input int n,
                              input int sc, output logic [1:0] p_end);
        int   last;
        int   k;
        logic [1:0] p;
        obs_t e;
        last = (n == 0) ? 2 : (n + 1) * sc;
        for (int j = 0; j <= last; j++) begin
            k = (n == 0) ? 0 : j / sc;
            if (k > n) k = n;
            p = dir ? p0 + 2'(k) : p0 - 2'(k);
            {e.a, e.b} = ab_of(p);
            e.busy  = (n > 0) && (j < (n + 1) * sc);
            e.done  = (n > 0) ? (j == (n + 1) * sc) : (j == 1);
            e.ready = !e.busy;
            exp_q.push_back(e);
        end
        p_end = dir ? p0 + 2'(n % 4) : p0 - 2'(n % 4);
    endtask

    task automatic start(input int sel, input logic dir, input logic [7:0] steps);
        v[sel] = 1'b1;
        d[sel] = dir;
        s[sel] = steps;
    endtask

    task automatic drain(input int sel, input string name, input int release_at,
                         input int swap_at, input logic sdir, input logic [7:0] ssteps);
        int   idx;
        obs_t e, o;
        logic [1:0] dp;
        idx = 0;
        while (exp_q.size() > 0) begin
            @(negedge clk);
            e = exp_q.pop_front();
            o = get_obs(sel);
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL %s[%0d] dut%0d got a=%b b=%b busy=%b done=%b ready=%b exp a=%b b=%b busy=%b done=%b ready=%b",
                         name, idx, sel, o.a, o.b, o.busy, o.done, o.ready,
                         e.a, e.b, e.busy, e.done, e.ready);
            end
            if ({o.a, o.b} != prev_ab) begin
                dp = ph_of({o.a, o.b}) - ph_of(prev_ab);
                if (dp == 2'd1) up_cnt++;
                else dn_cnt++;
                prev_ab = {o.a, o.b};
            end
            if (idx == swap_at) begin
                d[sel] = sdir;
                s[sel] = ssteps;
            end
            if (idx == release_at) v[sel] = 1'b0;
            idx++;
        end
    endtask

    task automatic check_idle_zero(input string name);
        obs_t o;
        for (int sel = 0; sel < 2; sel++) begin
            o = get_obs(sel);
            total++;
            if (o !== 5'b00001) begin
                bad++;
                $display("FAIL %s dut%0d got {a,b,busy,done,ready}=%b exp 00001", name, sel, o);
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            v[i] = 1'b0; d[i] = 1'b0; s[i] = 8'd0;
        end
        @(negedge clk);
        check_idle_zero("reset_first_edge");
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_idle_zero("reset_released");
        ph0 = 2'd0;
        ph1 = 2'd0;
    endtask

    task automatic test_forward;
        start(0, 1'b1, 8'd4);
        push_trace(ph0, 1'b1, 4, 4, ph0);
        drain(0, "forward", 0, -1, 1'b0, 8'd0);
    endtask

    task automatic test_reverse_undo;
        start(0, 1'b0, 8'd3);
        push_trace(ph0, 1'b0, 3, 4, ph0);
        drain(0, "reverse", 0, -1, 1'b0, 8'd0);
        start(0, 1'b1, 8'd1);
        push_trace(ph0, 1'b1, 1, 4, ph0);
        drain(0, "undo", 0, -1, 1'b0, 8'd0);
        total++;
        if ({a[0], b[0]} !== 2'b11) begin
            bad++;
            $display("FAIL undo_final got ab=%b exp 11", {a[0], b[0]});
        end
    endtask

    task automatic test_zero;
        start(0, 1'b1, 8'd0);
        push_trace(ph0, 1'b1, 0, 4, ph0);
        drain(0, "zero_steps", 0, -1, 1'b0, 8'd0);
    endtask

    task automatic test_busy_reject;
        logic [1:0] p_mid;
        start(0, 1'b1, 8'd2);
        push_trace(ph0, 1'b1, 2, 4, p_mid);
        push_trace(p_mid, 1'b0, 5, 4, ph0);
        // Swap to the other command right after acceptance, hold valid until
        // it is taken at the edge ending the done cycle (index 13).
        drain(0, "busy_reject", 13, 0, 1'b0, 8'd5);
    endtask

    task automatic test_max_count;
        prev_ab = {a[1], b[1]};
        up_cnt  = 0;
        dn_cnt  = 0;
        start(1, 1'b1, 8'd255);
        push_trace(ph1, 1'b1, 255, 2, ph1);
        drain(1, "max_count", 0, -1, 1'b0, 8'd0);
        total++;
        if (up_cnt !== 255 || dn_cnt !== 0) begin
            bad++;
            $display("FAIL max_loopback got up=%0d down=%0d exp up=255 down=0", up_cnt, dn_cnt);
        end
        total++;
        if ({a[1], b[1]} !== 2'b01) begin
            bad++;
            $display("FAIL max_final got ab=%b exp 01", {a[1], b[1]});
        end
    endtask

    task automatic test_reset_midrun;
        obs_t o;
        start(0, 1'b1, 8'd6);
        @(negedge clk);
        v[0] = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_idle_zero("reset_midrun");
        @(negedge clk);
        reset = 1'b0;
        ph0 = 2'd0;
        ph1 = 2'd0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            o = get_obs(0);
            total++;
            if (o !== 5'b00001) begin
                bad++;
                $display("FAIL reset_abort[%0d] got {a,b,busy,done,ready}=%b exp 00001", i, o);
            end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        prev_ab = 2'b00;
        up_cnt  = 0;
        dn_cnt  = 0;
        test_reset();
        test_forward();
        test_reverse_undo();
        test_zero();
        test_busy_reject();
        test_max_count();
        test_reset_midrun();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
